// File: rtl/reg_ce_write_arbiter_if.sv
// Write-port bundle between N client blocks and the shared clock-enabled register arbiter.
interface reg_ce_write_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 16
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  // Handshake: a client raises req[i] and holds it with stable data until gnt[i] is seen;
  // a write happens in every cycle where gnt[i] & req[i] (reg_ce=1). lock[i] asks to keep ownership.
  logic [N-1:0]       req;
  logic [N-1:0]       lock;
  logic [N*WIDTH-1:0] data;
  logic [N-1:0]       gnt;
  logic [IDW-1:0]     gnt_id;
  logic               reg_ce;
  logic [WIDTH-1:0]   reg_in;
  logic               busy;

  modport master (
    output req, lock, data,
    input  gnt, gnt_id, reg_ce, reg_in, busy
  );

  modport slave (
    input  req, lock, data,
    output gnt, gnt_id, reg_ce, reg_in, busy
  );
endinterface

// File: rtl/reg_ce_write_arbiter.sv
// Round-robin arbiter for the write port of a shared clock-enabled register,
// with bounded multi-cycle locked ownership for burst updates.
module reg_ce_write_arbiter #(
  parameter int N        = 4,
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  reg_ce_write_arbiter_if.slave bus,
  output logic                  dbg_state_o
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int HW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic           any_req;
  logic           found;
  logic           cont;
  logic [IDW-1:0] win_id;
  int             after_g;
  int             base;
  int             idx;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      hold_q   <= hold_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    any_req  = |bus.req;
    found    = 1'b0;
    win_id   = '0;
    idx      = 0;

    after_g = int'(gnt_id_q) + 1;
    if (after_g >= N) after_g = 0;

    cont = (state_q == OWN) && bus.lock[gnt_id_q] && bus.req[gnt_id_q] &&
           (hold_q < HOLD_LAST);

    // On release the scan starts just past the owner, so the owner is only
    // re-picked when nobody else requests and it still does.
    base = (state_q == OWN) ? after_g : int'(ptr_q);
    for (int k = 0; k < N; k++) begin
      idx = base + k;
      if (idx >= N) idx = idx - N;
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        win_id = IDW'(idx);
      end
    end

    if (state_q == IDLE) begin
      if (any_req) begin
        state_d       = OWN;
        gnt_d         = '0;
        gnt_d[win_id] = 1'b1;
        gnt_id_d      = win_id;
        hold_d        = '0;
      end
    end else if (cont) begin
      hold_d = hold_q + HW'(1);
    end else begin
      ptr_d  = IDW'(after_g);
      hold_d = '0;
      if (any_req) begin
        gnt_d         = '0;
        gnt_d[win_id] = 1'b1;
        gnt_id_d      = win_id;
      end else begin
        state_d  = IDLE;
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    end
  end

  always_comb begin
    bus.reg_ce = |(gnt_q & bus.req);
    bus.reg_in = '0;
    if (bus.reg_ce) bus.reg_in = bus.data[int'(gnt_id_q)*WIDTH +: WIDTH];
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = |gnt_q;
  assign dbg_state_o = state_q;

endmodule
